// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register-number width and the pipeline sequencer state encoding.
package cpu_types_pkg;

  localparam int REG_W = 5;

  typedef logic [REG_W-1:0] regbits_t;

  typedef enum logic [1:0] {PS_RUN, PS_DWAIT, PS_HALT} pipe_state_t;

endpackage

// File: rtl/pipeline_sequencer_hazard_detect.sv
// Load-use hazard compare between the EX-stage load destination and the ID-stage sources.
module hazard_detect
  import cpu_types_pkg::*;
(
  input  logic     ex_memtoreg,
  input  regbits_t ex_wsel,
  input  regbits_t id_rs,
  input  regbits_t id_rt,
  output logic     lu_stall
);

  // Register 0 is hardwired, so a load targeting it never creates a dependency.
  assign lu_stall = ex_memtoreg && (ex_wsel != '0) &&
                    ((ex_wsel == id_rs) || (ex_wsel == id_rt));

endmodule

// File: rtl/pipeline_sequencer.sv
// Stall/flush sequencer for the five-stage pipeline.
// Optional feature: define PIPE_STALL_CNT_EN to add the saturating stall_count output.
module pipeline_sequencer
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic        ex_memtoreg,
  input  regbits_t    ex_wsel,
  input  regbits_t    id_rs,
  input  regbits_t    id_rt,
  input  logic        ex_redirect,
  input  logic        halt_wb,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        memwb_flush,
`ifdef PIPE_STALL_CNT_EN
  output logic [31:0] stall_count,
`endif
  output logic        halted
);

  pipe_state_t state_q;
  logic        luStall;
  logic        dataWait;
  logic        haltNow;

  hazard_detect u_hazard (
    .ex_memtoreg (ex_memtoreg),
    .ex_wsel     (ex_wsel),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .lu_stall    (luStall)
  );

  // Once frozen, the wait persists until dhit even if the MEM request drops.
  assign dataWait = (((mem_ren || mem_wen) && !dhit) ||
                     (state_q == PS_DWAIT && !dhit));
  assign haltNow  = (state_q == PS_HALT) || halt_wb;

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    halted      = 1'b0;
    if (RST) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
    end else if (haltNow) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
      halted   = 1'b1;
    end else if (dataWait) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
    end else if (ex_redirect) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (luStall) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end else if (!ihit) begin
      pc_en      = 1'b0;
      ifid_flush = 1'b1;
    end
  end

  // PS_HALT is sticky; only the asynchronous reset leaves it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= PS_RUN;
    end else if (state_q != PS_HALT) begin
      if (halt_wb)       state_q <= PS_HALT;
      else if (dataWait) state_q <= PS_DWAIT;
      else               state_q <= PS_RUN;
    end
  end

`ifdef PIPE_STALL_CNT_EN
  logic [31:0] stallCnt_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stallCnt_q <= '0;
    end else if (state_q != PS_HALT && !pc_en && stallCnt_q != 32'hFFFF_FFFF) begin
      stallCnt_q <= stallCnt_q + 32'd1;
    end
  end

  assign stall_count = stallCnt_q;
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer: directed vector table, hand sequences, random vs model.
// Covers the stall_count output when PIPE_STALL_CNT_EN is defined.
module tb_pipeline_sequencer;
  import cpu_types_pkg::*;

  typedef struct {
    logic       rst;
    logic       ihit;
    logic       dhit;
    logic       ren;
    logic       wen;
    logic       memtoreg;
    logic [4:0] wsel;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       redirect;
    logic       halt;
    logic [9:0] exp;
  } vec_t;

  // Output bundle order: pc, ifid, idex, exmem, memwb enables; ifid, idex, exmem, memwb flushes; halted.
  localparam logic [9:0] O_RESET = 10'b00000_1111_0;
  localparam logic [9:0] O_HALT  = 10'b00000_0000_1;
  localparam logic [9:0] O_DWAIT = 10'b00001_0001_0;
  localparam logic [9:0] O_REDIR = 10'b11111_1100_0;
  localparam logic [9:0] O_LU    = 10'b00111_0100_0;
  localparam logic [9:0] O_MISS  = 10'b01111_1000_0;
  localparam logic [9:0] O_RUN   = 10'b11111_0000_0;

  logic       CLK = 1'b0;
  logic       RST, ihit, dhit, mem_ren, mem_wen, ex_memtoreg, ex_redirect, halt_wb;
  regbits_t   ex_wsel, id_rs, id_rt;
  logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic       ifid_flush, idex_flush, exmem_flush, memwb_flush, halted;
  logic [31:0] stall_count;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  pipeline_sequencer dut (
    .CLK         (CLK),
    .RST         (RST),
    .ihit        (ihit),
    .dhit        (dhit),
    .mem_ren     (mem_ren),
    .mem_wen     (mem_wen),
    .ex_memtoreg (ex_memtoreg),
    .ex_wsel     (ex_wsel),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .ex_redirect (ex_redirect),
    .halt_wb     (halt_wb),
    .pc_en       (pc_en),
    .ifid_en     (ifid_en),
    .idex_en     (idex_en),
    .exmem_en    (exmem_en),
    .memwb_en    (memwb_en),
    .ifid_flush  (ifid_flush),
    .idex_flush  (idex_flush),
    .exmem_flush (exmem_flush),
    .memwb_flush (memwb_flush),
`ifdef PIPE_STALL_CNT_EN
    .stall_count (stall_count),
`endif
    .halted      (halted)
  );

`ifndef PIPE_STALL_CNT_EN
  assign stall_count = '0;
`endif

  function automatic vec_t mk(input logic r, input logic ih, input logic dh, input logic rn,
                              input logic wn, input logic mr, input int ws, input int s,
                              input int t, input logic rd, input logic h, input logic [9:0] e);
    vec_t v;
    v.rst = r; v.ihit = ih; v.dhit = dh; v.ren = rn; v.wen = wn; v.memtoreg = mr;
    v.wsel = 5'(ws); v.rs = 5'(s); v.rt = 5'(t); v.redirect = rd; v.halt = h; v.exp = e;
    return v;
  endfunction

  // Behavioural reference: rule list evaluated top-down from the pipeline's "frozen" and "stopped" facts.
  function automatic logic [9:0] modelOut(input vec_t v, input logic frozen, input logic stopped);
    logic memBusy;
    logic dependent;
    memBusy   = (v.ren | v.wen) & ~v.dhit;
    dependent = v.memtoreg && v.wsel != 0 && (v.wsel == v.rs || v.wsel == v.rt);
    if (v.rst)                      return O_RESET;
    if (stopped || v.halt)          return O_HALT;
    if (memBusy || (frozen && !v.dhit)) return O_DWAIT;
    if (v.redirect)                 return O_REDIR;
    if (dependent)                  return O_LU;
    if (!v.ihit)                    return O_MISS;
    return O_RUN;
  endfunction

  task automatic applyStimulus(input vec_t v);
    RST = v.rst; ihit = v.ihit; dhit = v.dhit; mem_ren = v.ren; mem_wen = v.wen;
    ex_memtoreg = v.memtoreg; ex_wsel = v.wsel; id_rs = v.rs; id_rt = v.rt;
    ex_redirect = v.redirect; halt_wb = v.halt;
  endtask

  task automatic checkOutput(input string name, input logic [9:0] exp);
    logic [9:0] got;
    got = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush, halted};
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%b want=%b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic checkCount(input string name, input logic [31:0] exp);
`ifdef PIPE_STALL_CNT_EN
    total++;
    if (stall_count !== exp) begin
      bad++;
      $display("[TB] FAIL %s stall_count got=%0d want=%0d", name, stall_count, exp);
    end
`else
    if (name.len() == 0 && exp == 0) $display("[TB] no counter");
`endif
  endtask

  // Drive at posedge+1, sample at the falling edge, then advance to the next posedge+1.
  task automatic step(input vec_t v, input string name);
    applyStimulus(v);
    #4;
    checkOutput(name, v.exp);
    @(posedge CLK);
    #1;
  endtask

  vec_t tbl[20];
  vec_t v;
  logic frozen, stopped;
  logic [31:0] cnt;
  logic [9:0] e;

  initial begin
    tbl[0]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RESET);
    tbl[1]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN);
    tbl[2]  = mk(0, 1, 0, 0, 0, 1, 5, 1, 5, 0, 0, O_LU);
    tbl[3]  = mk(0, 1, 0, 0, 0, 0, 5, 1, 5, 0, 0, O_RUN);
    tbl[4]  = mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, O_RUN);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_MISS);
    tbl[6]  = mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, O_DWAIT);
    tbl[7]  = mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, O_DWAIT);
    tbl[8]  = mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, O_DWAIT);
    tbl[9]  = mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, O_RUN);
    tbl[10] = mk(0, 0, 0, 0, 0, 1, 7, 7, 2, 1, 0, O_REDIR);
    tbl[11] = mk(0, 1, 0, 0, 1, 1, 3, 3, 0, 1, 0, O_DWAIT);
    tbl[12] = mk(0, 1, 0, 0, 1, 1, 3, 3, 0, 1, 0, O_DWAIT);
    tbl[13] = mk(0, 1, 1, 0, 1, 1, 3, 3, 0, 1, 0, O_REDIR);
    tbl[14] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN);
    tbl[15] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, O_HALT);
    tbl[16] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_HALT);
    tbl[17] = mk(0, 0, 0, 1, 0, 1, 4, 4, 4, 1, 0, O_HALT);
    tbl[18] = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RESET);
    tbl[19] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN);

    applyStimulus(tbl[0]);
    @(posedge CLK);
    #1;
    checkCount("reset_count", 32'd0);

    for (int i = 0; i < 20; i++) begin
      step(tbl[i], $sformatf("vec%0d", i));
    end

    // Hand sequence: reset, one clean cycle, three-cycle data wait, release on dhit.
    step(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RESET), "seq_reset");
    checkCount("seq_count_zero", 32'd0);
    step(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN), "seq_run");
    for (int i = 0; i < 3; i++)
      step(mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, O_DWAIT), $sformatf("seq_wait%0d", i));
    step(mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, O_RUN), "seq_release");
    checkCount("seq_count_three", 32'd3);

    // Hand sequence: halt arrives during a data wait, then a reset pulse mid-halt.
    step(mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, O_DWAIT), "hw_wait");
    step(mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1, O_HALT), "hw_halt");
    step(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, O_HALT), "hw_stay");
    step(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, O_HALT), "hw_stay2");
    step(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, O_RESET), "hw_reset");
    step(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN), "hw_run");

    // Randomized phase against the reference model.
    applyStimulus(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RESET));
    @(posedge CLK);
    #1;
    frozen = 0; stopped = 0; cnt = 0;
    for (int n = 0; n < 500; n++) begin
      v.rst      = ($urandom_range(59) == 0);
      v.ihit     = ($urandom_range(3) != 0);
      v.dhit     = $urandom_range(1);
      v.ren      = ($urandom_range(4) == 0);
      v.wen      = ($urandom_range(6) == 0);
      v.memtoreg = ($urandom_range(2) == 0);
      v.wsel     = 5'($urandom_range(3));
      v.rs       = 5'($urandom_range(3));
      v.rt       = 5'($urandom_range(3));
      v.redirect = ($urandom_range(5) == 0);
      v.halt     = ($urandom_range(79) == 0);
      e = modelOut(v, frozen, stopped);
      v.exp = e;
      applyStimulus(v);
      #4;
      checkOutput($sformatf("rand%0d", n), e);
      checkCount($sformatf("rand_cnt%0d", n), cnt);
      if (v.rst) begin
        frozen = 0; stopped = 0; cnt = 0;
      end else begin
        if (!stopped && !e[9] && cnt != 32'hFFFF_FFFF) cnt = cnt + 1;
        if (stopped || v.halt) stopped = 1;
        else frozen = ((v.ren | v.wen) & ~v.dhit) | (frozen & ~v.dhit);
      end
      @(posedge CLK);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_sequencer.md
# pipeline_sequencer

Central stall/flush controller for the five-stage pipeline. Each cycle it drives the enable and flush inputs of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves data-memory wait, instruction-fetch miss, load-use hazard, control redirect and halt, and sequences them with a small state machine so that every stage advances, holds or is cleared together.

## Interface
- Parameters: none; register-number width comes from the shared package (5 bits).
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- ihit  in  1  instruction memory returned valid data this cycle.
- dhit  in  1  data memory completed the MEM-stage access this cycle.
- mem_ren, mem_wen  in  1 each  MEM-stage instruction reads / writes data memory.
- ex_memtoreg  in  1  EX-stage instruction is a load.
- ex_wsel  in  5  EX-stage destination register.
- id_rs, id_rt  in  5 each  source registers of the ID-stage instruction.
- ex_redirect  in  1  EX stage resolved a taken branch or jump; PC input already carries the target.
- halt_wb  in  1  the halt instruction is in WB.
- pc_en  out  1  PC update enable.
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register enables.
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  synchronous clear to bubble.
- halted  out  1  pipeline permanently stopped.
- stall_count  out  32  stall-cycle counter; present only with PIPE_STALL_CNT_EN.

## Operation
- States: PS_RUN, PS_DWAIT, PS_HALT.
- Outputs depend on the state and the current inputs. Priority, highest first:
  1. PS_HALT or halt_wb: all enables and flushes are 0; halted=1.
  2. Data wait, when (mem_ren|mem_wen) & !dhit: pc_en, ifid_en, idex_en and exmem_en are 0; memwb_en=1 and memwb_flush=1, so a bubble enters WB.
  3. Redirect, when ex_redirect: pc_en=1; ifid_flush=1; idex_flush=1; exmem_en=1; memwb_en=1.
  4. Load-use, when ex_memtoreg & ex_wsel!=0 & (ex_wsel==id_rs | ex_wsel==id_rt): pc_en=0, ifid_en=0, idex_flush=1; EX/MEM and MEM/WB advance.
  5. Fetch miss, when !ihit: pc_en=0, ifid_flush=1; all later stages advance.
  6. Otherwise: all enables 1, all flushes 0.
- Under every rule, a flush output is never asserted together with a 0 enable for the same register; flush takes effect only when the enable is 1.
- Transitions:
  - PS_RUN → PS_DWAIT on a data wait.
  - PS_DWAIT → PS_RUN on dhit.
  - Any state → PS_HALT when halt_wb=1.
  - PS_HALT exits only on RST.
- In PS_DWAIT, a redirect or load-use condition is ignored; EX is frozen, so it is re-evaluated on the dhit cycle.

## Timing
- While RST=1: state=PS_RUN; all *_en=0; all *_flush=1; halted=0; stall_count=0.
- After RST falls, outputs follow the rules above from the first clock edge.
- Zero-cycle decision latency: outputs settle combinationally in the same cycle as their inputs. The state register updates on the rising CLK edge.
- A load-use stall lasts exactly 1 cycle unless a data wait extends it.
- A data wait lasts until dhit, plus 0 extra cycles; the dhit cycle itself advances all stages.
- A redirect costs exactly 2 bubbles, in IF/ID and ID/EX.
- Simultaneous events:
  - data wait with redirect: freeze first, redirect on the dhit cycle.
  - redirect with load-use: redirect wins, because the dependent instruction is squashed.
  - redirect with !ihit: redirect wins, and the target fetch then proceeds.
- RST asserted mid-wait or in PS_HALT returns the block to PS_RUN immediately (asynchronous).

## Configuration
- PIPE_STALL_CNT_EN defined: 32-bit stall_count increments on every clock with pc_en=0 while not in PS_HALT and RST=0. It saturates at 0xFFFFFFFF.
- PIPE_STALL_CNT_EN undefined: the stall_count port and its logic are absent; all other behaviour is identical.

## Structure
- In cpu_types_pkg:
  - typedef enum logic [1:0] pipe_state_t {PS_RUN, PS_DWAIT, PS_HALT};
  - regbits_t, the 5-bit register number, reused for ex_wsel, id_rs and id_rt.
- One sub-module, hazard_detect: combinational load-use compare with output lu_stall.
- The priority encoder, the FSM and the optional counter live in pipeline_sequencer.

## Test plan
- Reset, then ihit=1 with no hazards → all *_en=1, flushes 0, state PS_RUN, stall_count=0.
- ex_memtoreg=1, ex_wsel=5, id_rt=5 for 1 cycle → pc_en=0, ifid_en=0, idex_flush=1 for exactly 1 cycle; with ex_wsel=0 → no stall.
- mem_ren=1 and dhit held 0 for 3 cycles, then 1 → 3 cycles frozen with memwb_flush=1, state PS_DWAIT; the 4th cycle advances all stages; stall_count=3.
- ex_redirect=1 together with a load-use match and ihit=0 → pc_en=1, ifid_flush=1, idex_flush=1.
- ex_redirect=1 during a data wait → frozen until dhit; the redirect outputs appear on the dhit cycle.
- halt_wb=1 → halted=1 and all enables 0 thereafter, regardless of inputs; RST pulse mid-halt → PS_RUN with halted=0.
